// File: rtl/gte_engine.sv
// Geometry transform engine: 64-entry register file with formatted reads and a
// multi-cycle command unit (NCLIP, SQR, AVSZ3, AVSZ4) gated by a busy counter.
module gte_engine (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  i_regID,
  input  logic        i_WritReg,
  input  logic [31:0] i_dataIn,
  output logic [31:0] o_dataOut,
  input  logic [24:0] i_Instruction,
  input  logic        i_run,
  input  logic        i_DIP_USEFASTGTE,
  input  logic        i_DIP_FIXWIDE,
  output logic        o_executing
);

  logic [31:0] regs [64];
  logic [3:0]  cnt;
  logic [5:0]  op_q;
  logic        sf_q;
  logic [3:0]  n_cmd;
  logic signed [47:0] nclip, w3, w4;
  logic [31:0] sqr_mac [3];
  logic [2:0]  sqr_clip;
  logic [16:0] otz3, otz4;
  logic        unused;

  assign unused = ^{i_DIP_FIXWIDE, i_Instruction[24:20], i_Instruction[18:6]};

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic signed [47:0] s48(input logic [15:0] v);
    return {{32{v[15]}}, v};
  endfunction

  function automatic logic signed [47:0] u48(input logic [15:0] v);
    return {32'd0, v};
  endfunction

  function automatic logic [4:0] col5(input logic [15:0] ir);
    logic signed [15:0] s;
    s = $signed(ir) >>> 7;
    if (s < 0)        return 5'd0;
    else if (s > 31)  return 5'd31;
    else              return s[4:0];
  endfunction

  function automatic logic [31:0] lzcr(input logic [31:0] v);
    logic [31:0] n;
    logic        done;
    n = 32'd1;
    done = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!done && v[i] == v[31]) n = n + 32'd1;
      else done = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [31:0] sq(input logic [15:0] ir, input logic sf);
    logic signed [31:0] v, p;
    v = {{16{ir[15]}}, ir};
    p = v * v;
    return sf ? 32'(p >>> 12) : 32'(p);
  endfunction

  // {clip, otz}: arithmetic >>12 then clamp to the unsigned 16-bit Z range
  function automatic logic [16:0] otz_calc(input logic signed [47:0] w);
    logic signed [47:0] sh;
    sh = w >>> 12;
    if (sh < 0)                 return {1'b1, 16'h0000};
    else if (sh > 48'sd65535)   return {1'b1, 16'hFFFF};
    else                        return {1'b0, sh[15:0]};
  endfunction

  function automatic logic [1:0] mac_flags(input logic signed [47:0] w);
    return {w > 48'sh0000_7FFF_FFFF, w < $signed(48'hFFFF_8000_0000)};
  endfunction

  always_comb begin
    nclip = s48(regs[12][15:0]) * s48(regs[13][31:16])
          + s48(regs[13][15:0]) * s48(regs[14][31:16])
          + s48(regs[14][15:0]) * s48(regs[12][31:16])
          - s48(regs[12][15:0]) * s48(regs[14][31:16])
          - s48(regs[13][15:0]) * s48(regs[12][31:16])
          - s48(regs[14][15:0]) * s48(regs[13][31:16]);
    w3 = s48(regs[61][15:0]) * (u48(regs[17][15:0]) + u48(regs[18][15:0]) + u48(regs[19][15:0]));
    w4 = s48(regs[62][15:0]) * (u48(regs[16][15:0]) + u48(regs[17][15:0])
                              + u48(regs[18][15:0]) + u48(regs[19][15:0]));
    otz3 = otz_calc(w3);
    otz4 = otz_calc(w4);
    for (int i = 0; i < 3; i++) begin
      sqr_mac[i]  = sq(regs[9+i][15:0], sf_q);
      sqr_clip[i] = sqr_mac[i] > 32'h0000_7FFF;
    end
  end

  always_comb begin
    n_cmd = 4'd2;
    if (!i_DIP_USEFASTGTE) begin
      case (i_Instruction[5:0])
        6'h28:   n_cmd = 4'd5;
        6'h2D:   n_cmd = 4'd5;
        6'h2E:   n_cmd = 4'd6;
        default: n_cmd = 4'd8;
      endcase
    end
  end

  always_comb begin
    o_dataOut = regs[i_regID];
    case (i_regID)
      6'd1, 6'd3, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11,
      6'd36, 6'd44, 6'd52, 6'd58, 6'd59, 6'd61, 6'd62:
        o_dataOut = sext16(regs[i_regID][15:0]);
      6'd7, 6'd16, 6'd17, 6'd18, 6'd19:
        o_dataOut = {16'd0, regs[i_regID][15:0]};
      6'd15:
        o_dataOut = regs[14];
      6'd28, 6'd29:
        o_dataOut = {17'd0, col5(regs[11][15:0]), col5(regs[10][15:0]), col5(regs[9][15:0])};
      6'd31:
        o_dataOut = lzcr(regs[30]);
      6'd63:
        o_dataOut = {(|regs[63][30:23]) | (|regs[63][18:13]), regs[63][30:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) regs[i] <= '0;
      cnt         <= '0;
      op_q        <= '0;
      sf_q        <= 1'b0;
      o_executing <= 1'b0;
    end else begin
      if (i_WritReg && !o_executing) begin
        case (i_regID)
          6'd15: begin
            regs[12] <= regs[13];
            regs[13] <= regs[14];
            regs[14] <= i_dataIn;
          end
          6'd28: begin
            regs[9]  <= {20'd0, i_dataIn[4:0], 7'd0};
            regs[10] <= {20'd0, i_dataIn[9:5], 7'd0};
            regs[11] <= {20'd0, i_dataIn[14:10], 7'd0};
          end
          6'd29, 6'd31: ;
          6'd63:   regs[63] <= i_dataIn & 32'h7FFF_F000;
          default: regs[i_regID] <= i_dataIn;
        endcase
      end
      // Accept clears FLAG after any same-cycle write; operands are read at completion
      if (i_run && !o_executing) begin
        regs[63]    <= '0;
        cnt         <= n_cmd;
        op_q        <= i_Instruction[5:0];
        sf_q        <= i_Instruction[19];
        o_executing <= 1'b1;
      end else if (o_executing) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          o_executing <= 1'b0;
          case (op_q)
            6'h06: begin
              regs[24] <= nclip[31:0];
              regs[63] <= {15'd0, mac_flags(nclip), 15'd0};
            end
            6'h28: begin
              for (int i = 0; i < 3; i++) begin
                regs[25+i] <= sqr_mac[i];
                regs[9+i]  <= sqr_clip[i] ? 32'h0000_7FFF : sqr_mac[i];
              end
              regs[63] <= {7'd0, sqr_clip[0], sqr_clip[1], sqr_clip[2], 22'd0};
            end
            6'h2D: begin
              regs[24] <= w3[31:0];
              regs[7]  <= {16'd0, otz3[15:0]};
              regs[63] <= {13'd0, otz3[16], 1'b0, mac_flags(w3), 15'd0};
            end
            6'h2E: begin
              regs[24] <= w4[31:0];
              regs[7]  <= {16'd0, otz4[15:0]};
              regs[63] <= {13'd0, otz4[16], 1'b0, mac_flags(w4), 15'd0};
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gte_engine.sv
// Directed bench for gte_engine: register formats, SXY FIFO, LZC, IRGB and the
// four commands with their busy periods, flags, write-while-busy and reset abort.
module tb_gte_engine;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  i_regID;
  logic        i_WritReg;
  logic [31:0] i_dataIn;
  logic [31:0] o_dataOut;
  logic [24:0] i_Instruction;
  logic        i_run;
  logic        i_DIP_USEFASTGTE;
  logic        i_DIP_FIXWIDE;
  logic        o_executing;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;

  gte_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .i_regID(i_regID), .i_WritReg(i_WritReg),
    .i_dataIn(i_dataIn), .o_dataOut(o_dataOut), .i_Instruction(i_Instruction),
    .i_run(i_run), .i_DIP_USEFASTGTE(i_DIP_USEFASTGTE), .i_DIP_FIXWIDE(i_DIP_FIXWIDE),
    .o_executing(o_executing)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic wr(input logic [5:0] id, input logic [31:0] d);
    @(negedge clk_i);
    i_regID = id; i_dataIn = d; i_WritReg = 1'b1;
    @(negedge clk_i);
    i_WritReg = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] id, input logic [31:0] exp);
    i_regID = id;
    #1;
    check(tag, o_dataOut, exp);
  endtask

  // Launch a command; optionally write a register in the accept cycle, and optionally
  // poke a write, a second run and a FAST flip during the first busy cycle.
  task automatic run_cmd(input logic [24:0] ins, input bit swr, input logic [5:0] sid,
                         input logic [31:0] sdat, input bit poke, output int n);
    @(negedge clk_i);
    i_Instruction = ins; i_run = 1'b1;
    if (swr) begin i_regID = sid; i_dataIn = sdat; i_WritReg = 1'b1; end
    @(negedge clk_i);
    i_run = 1'b0; i_WritReg = 1'b0;
    if (poke) begin
      i_run = 1'b1; i_WritReg = 1'b1; i_regID = 6'd0; i_dataIn = 32'h0000_DEAD;
      i_DIP_USEFASTGTE = ~i_DIP_USEFASTGTE;
    end
    n = 0;
    while (o_executing && n < 100) begin
      n++;
      @(negedge clk_i);
      i_run = 1'b0; i_WritReg = 1'b0;
    end
  endtask

  initial begin
    rst_i = 1'b1; i_regID = '0; i_WritReg = 1'b0; i_dataIn = '0; i_Instruction = '0;
    i_run = 1'b0; i_DIP_USEFASTGTE = 1'b0; i_DIP_FIXWIDE = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_exec", {31'd0, o_executing}, 32'd0);
    rd("rst_mac0", 6'd24, 32'd0);
    rd("rst_flag", 6'd63, 32'd0);

    wr(6'd1, 32'h0000_8001);  rd("vz0_sext", 6'd1, 32'hFFFF_8001);
    wr(6'd7, 32'hFFFF_1234);  rd("otz_zext", 6'd7, 32'h0000_1234);
    wr(6'd58, 32'h0000_FFFF); rd("c58_sext", 6'd58, 32'hFFFF_FFFF);
    wr(6'd2, 32'hDEAD_BEEF);  rd("vxy1_full", 6'd2, 32'hDEAD_BEEF);

    wr(6'd15, 32'd1); wr(6'd15, 32'd2); wr(6'd15, 32'd3);
    rd("sxy0", 6'd12, 32'd1); rd("sxy1", 6'd13, 32'd2);
    rd("sxy2", 6'd14, 32'd3); rd("sxyp", 6'd15, 32'd3);
    wr(6'd30, 32'h00FF_0000); rd("lzcr_8", 6'd31, 32'd8);
    wr(6'd30, 32'hFFFF_FFFF); rd("lzcr_32", 6'd31, 32'd32);
    wr(6'd30, 32'h4000_0000); rd("lzcr_1", 6'd31, 32'd1);

    wr(6'd28, 32'h0000_7FFF);
    rd("irgb_ir1", 6'd9, 32'h0000_0F80); rd("irgb_ir2", 6'd10, 32'h0000_0F80);
    rd("irgb_ir3", 6'd11, 32'h0000_0F80); rd("orgb", 6'd29, 32'h0000_7FFF);

    // NCLIP, slow: triangle (0,0),(10,0),(0,10); FLAG preset to prove it clears
    wr(6'd15, 32'h0000_0000); wr(6'd15, 32'h0000_000A); wr(6'd15, 32'h000A_0000);
    wr(6'd63, 32'hFFFF_FFFF); rd("flag_wr", 6'd63, 32'hFFFF_F000);
    run_cmd(25'h06, 1'b0, 6'd0, 32'd0, 1'b0, cyc);
    check("nclip_cyc", cyc, 32'd8);
    rd("nclip_mac0", 6'd24, 32'd100);
    rd("nclip_flag", 6'd63, 32'd0);

    // AVSZ3, slow: ZSF3 written in the accept cycle
    wr(6'd17, 32'h1000); wr(6'd18, 32'h1000); wr(6'd19, 32'h1000);
    run_cmd(25'h2D, 1'b1, 6'd61, 32'h0000_0555, 1'b0, cyc);
    check("avsz3_cyc", cyc, 32'd5);
    rd("avsz3_otz", 6'd7, 32'h0000_0FFF);
    rd("avsz3_mac0", 6'd24, 32'h00FF_F000);
    rd("avsz3_flag", 6'd63, 32'd0);

    // AVSZ4, fast, with overflow/clamp; poke during busy must be ignored
    wr(6'd16, 32'hFFFF); wr(6'd17, 32'hFFFF); wr(6'd18, 32'hFFFF); wr(6'd19, 32'hFFFF);
    wr(6'd62, 32'h0000_7FFF);
    i_DIP_USEFASTGTE = 1'b1;
    run_cmd(25'h2E, 1'b0, 6'd0, 32'd0, 1'b1, cyc);
    check("avsz4_cyc", cyc, 32'd2);
    rd("avsz4_otz", 6'd7, 32'h0000_FFFF);
    rd("avsz4_mac0", 6'd24, 32'hFFFA_0004);
    rd("avsz4_flag", 6'd63, 32'h8005_0000);
    rd("busy_wr_ignored", 6'd0, 32'd0);
    check("fast_flip_exec", {31'd0, o_executing}, 32'd0);

    // SQR sf=0 saturates IR1; fast flag was flipped back to 0 by the poke
    i_DIP_USEFASTGTE = 1'b0;
    wr(6'd9, 32'h0200); wr(6'd10, 32'h0); wr(6'd11, 32'h0);
    run_cmd(25'h28, 1'b0, 6'd0, 32'd0, 1'b0, cyc);
    check("sqr_cyc", cyc, 32'd5);
    rd("sqr_mac1", 6'd25, 32'h0004_0000);
    rd("sqr_ir1", 6'd9, 32'h0000_7FFF);
    rd("sqr_mac2", 6'd26, 32'd0);
    rd("sqr_flag", 6'd63, 32'h8100_0000);

    // SQR sf=1 on a negative IR1
    wr(6'd9, 32'h0000_F000);
    run_cmd(25'h08_0028, 1'b0, 6'd0, 32'd0, 1'b0, cyc);
    rd("sqrsf_mac1", 6'd25, 32'h0000_1000);
    rd("sqrsf_ir1", 6'd9, 32'h0000_1000);
    rd("sqrsf_flag", 6'd63, 32'd0);

    // Unknown opcode: only FLAG clears, busy 8
    wr(6'd63, 32'h0000_1000); rd("flag_b12", 6'd63, 32'h0000_1000);
    run_cmd(25'h01, 1'b0, 6'd0, 32'd0, 1'b0, cyc);
    check("nop_cyc", cyc, 32'd8);
    rd("nop_flag", 6'd63, 32'd0);
    rd("nop_ir1", 6'd9, 32'h0000_1000);

    // Reset mid-command aborts
    @(negedge clk_i);
    i_Instruction = 25'h06; i_run = 1'b1;
    @(negedge clk_i);
    i_run = 1'b0;
    @(negedge clk_i);
    check("abort_busy", {31'd0, o_executing}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_exec", {31'd0, o_executing}, 32'd0);
    rd("abort_mac0", 6'd24, 32'd0);
    rd("abort_sxy2", 6'd14, 32'd0);
    repeat (10) @(negedge clk_i);
    rd("abort_after", 6'd24, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
